// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access FSM, branch resolve, MEM/WB register
//
// Optional feature macro: MEM_TIMEOUT_EN (ACCESS timeout counter plus sticky mem_err)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid .. mem_write    EX/MEM register contents (data + control)
//   stall                    hold EX/MEM and earlier stages (combinational)
//   pc_src, pc_target        branch decision and target (combinational)
//   dmem_req/we/addr/wdata   registered data-memory request
//   dmem_ack, dmem_rdata     memory completion and load data
//   wb_*                     MEM/WB register outputs
//   mem_err                  sticky access-timeout flag
module mem_stage #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int PC_W    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [4:0]        rd_addr,
    input  logic [PC_W-1:0]   pc_branch,
    input  logic              zero,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              branch,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              stall,
    output logic              pc_src,
    output logic [PC_W-1:0]   pc_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_alu_data,
    output logic [4:0]        wb_rd_addr,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic              mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_mem_data_q, wb_mem_data_d;
    logic [DATA_W-1:0] wb_alu_data_q, wb_alu_data_d;
    logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic              wb_reg_write_q, wb_reg_write_d;

    logic mem_op;
    logic timeout_hit;
    logic complete;

    assign mem_op = in_valid & (mem_read | mem_write);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    // cnt_q counts completed ACCESS cycles; the TIMEOUT-th ACCESS cycle ends the access.
    assign timeout_hit = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d     = '0;
        mem_err_d = mem_err_q;
        if (state_q == ACCESS && !complete) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (timeout_hit && !dmem_ack) begin
            mem_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign timeout_hit        = 1'b0;
    assign mem_err            = 1'b0;
`endif

    assign complete  = (state_q == ACCESS) && (dmem_ack || timeout_hit);
    assign pc_src    = in_valid & branch & zero;
    assign pc_target = pc_branch;

    // stall drops in the completion cycle so EX/MEM advances on the same edge
    // that writes the finished instruction into MEM/WB.
    always_comb begin
        if (state_q == IDLE) begin
            stall = mem_op;
        end else begin
            stall = !complete;
        end
    end

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        wb_valid_d      = 1'b0;
        wb_mem_data_d   = wb_mem_data_q;
        wb_alu_data_d   = wb_alu_data_q;
        wb_rd_addr_d    = wb_rd_addr_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_reg_write_d  = wb_reg_write_q;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    // write wins when both read and write are set
                    state_d      = ACCESS;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = mem_write;
                    dmem_addr_d  = alu_result[ADDR_W-1:0];
                    dmem_wdata_d = rs2_data;
                end else begin
                    wb_valid_d      = in_valid;
                    wb_mem_data_d   = '0;
                    wb_alu_data_d   = alu_result;
                    wb_rd_addr_d    = rd_addr;
                    wb_mem_to_reg_d = mem_to_reg;
                    wb_reg_write_d  = reg_write;
                end
            end
            ACCESS: begin
                if (complete) begin
                    state_d         = IDLE;
                    dmem_req_d      = 1'b0;
                    wb_valid_d      = 1'b1;
                    // a timed-out load returns zero rather than whatever is on the bus
                    wb_mem_data_d   = (dmem_we_q || !dmem_ack) ? '0 : dmem_rdata;
                    wb_alu_data_d   = alu_result;
                    wb_rd_addr_d    = rd_addr;
                    wb_mem_to_reg_d = mem_to_reg;
                    wb_reg_write_d  = reg_write;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            wb_valid_q      <= 1'b0;
            wb_mem_data_q   <= '0;
            wb_alu_data_q   <= '0;
            wb_rd_addr_q    <= '0;
            wb_mem_to_reg_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            wb_valid_q      <= wb_valid_d;
            wb_mem_data_q   <= wb_mem_data_d;
            wb_alu_data_q   <= wb_alu_data_d;
            wb_rd_addr_q    <= wb_rd_addr_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_reg_write_q  <= wb_reg_write_d;
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign wb_alu_data   = wb_alu_data_q;
    assign wb_rd_addr    = wb_rd_addr_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_reg_write  = wb_reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] alu_result;
    logic [63:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [31:0] pc_branch;
    logic        zero, mem_to_reg, reg_write, branch, mem_read, mem_write;
    logic        stall, pc_src;
    logic [31:0] pc_target;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic [63:0] wb_mem_data, wb_alu_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_mem_to_reg, wb_reg_write, mem_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(64), .ADDR_W(32), .PC_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .rs2_data(rs2_data), .rd_addr(rd_addr), .pc_branch(pc_branch), .zero(zero),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .stall(stall), .pc_src(pc_src),
        .pc_target(pc_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_mem_data(wb_mem_data),
        .wb_alu_data(wb_alu_data), .wb_rd_addr(wb_rd_addr),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; alu_result = '0; rs2_data = '0; rd_addr = '0; pc_branch = '0;
        zero = 0; mem_to_reg = 0; reg_write = 0; branch = 0; mem_read = 0; mem_write = 0;
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 0; dmem_rdata = '0;
        clear_inputs();
        tick(); tick();
        chk("reset_dmem_req", dmem_req, 0);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_wb_alu", wb_alu_data, 0);
        chk("reset_mem_err", mem_err, 0);
        chk("reset_stall", stall, 0);
        rst = 1'b0;
        tick();

        // plain ALU op
        in_valid = 1; alu_result = 64'h2A; rd_addr = 5; reg_write = 1;
        #1 chk("alu_stall", stall, 0);
        tick();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_alu", wb_alu_data, 64'h2A);
        chk("alu_wb_rd", wb_rd_addr, 5);
        chk("alu_wb_regwrite", wb_reg_write, 1);
        chk("alu_wb_mem", wb_mem_data, 0);
        chk("alu_stall_after", stall, 0);
        clear_inputs();

        // load, ack in the third ACCESS cycle
        in_valid = 1; mem_read = 1; alu_result = 64'h100; rd_addr = 7;
        mem_to_reg = 1; reg_write = 1;
        #1 chk("ld_stall_idle", stall, 1);
        tick();
        chk("ld_req", dmem_req, 1);
        chk("ld_addr", dmem_addr, 64'h100);
        chk("ld_we", dmem_we, 0);
        for (int i = 0; i < 2; i++) begin
            chk("ld_wait_stall", stall, 1);
            chk("ld_wait_wb_valid", wb_valid, 0);
            tick();
            chk("ld_wait_req", dmem_req, 1);
        end
        dmem_ack = 1; dmem_rdata = 64'hDEADBEEF;
        #1 chk("ld_ack_stall", stall, 0);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        clear_inputs();
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_mem", wb_mem_data, 64'hDEADBEEF);
        chk("ld_wb_rd", wb_rd_addr, 7);
        chk("ld_wb_m2r", wb_mem_to_reg, 1);
        chk("ld_req_drop", dmem_req, 0);

        // store with immediate ack: two-cycle latency
        in_valid = 1; mem_write = 1; rs2_data = 64'h55; alu_result = 64'h8;
        tick();
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_wdata", dmem_wdata, 64'h55);
        chk("st_addr", dmem_addr, 64'h8);
        dmem_ack = 1; dmem_rdata = 64'h1234;
        #1 chk("st_ack_stall", stall, 0);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        clear_inputs();
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_mem", wb_mem_data, 0);
        chk("st_wb_alu", wb_alu_data, 64'h8);

        // read and write both set -> store
        in_valid = 1; mem_read = 1; mem_write = 1; alu_result = 64'h20; rs2_data = 64'h77;
        tick();
        chk("rw_we", dmem_we, 1);
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        clear_inputs();
        chk("rw_wb_mem", wb_mem_data, 0);

        // ack while idle is ignored
        dmem_ack = 1; dmem_rdata = 64'hAAAA;
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        chk("idle_ack_wb_valid", wb_valid, 0);
        chk("idle_ack_req", dmem_req, 0);

        // branch resolution
        in_valid = 1; branch = 1; zero = 1; pc_branch = 32'h40;
        #1 chk("br_pc_src", pc_src, 1);
        chk("br_target", pc_target, 32'h40);
        zero = 0;
        #1 chk("br_not_taken", pc_src, 0);
        zero = 1; in_valid = 0;
        #1 chk("br_invalid", pc_src, 0);
        clear_inputs();
        tick();

        // async reset with a load in flight, then a late ack
        in_valid = 1; mem_read = 1; alu_result = 64'h300;
        tick();
        chk("rst_pre_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_req", dmem_req, 0);
        chk("rst_async_wb_valid", wb_valid, 0);
        chk("rst_async_wb_alu", wb_alu_data, 0);
        clear_inputs();
        tick();
        rst = 1'b0;
        dmem_ack = 1; dmem_rdata = 64'hBEEF;
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        chk("late_ack_wb_valid", wb_valid, 0);
        chk("late_ack_wb_mem", wb_mem_data, 0);
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_stall", stall, 0);

`ifdef MEM_TIMEOUT_EN
        // load never acked: completes on the 16th ACCESS cycle
        in_valid = 1; mem_read = 1; alu_result = 64'h400;
        tick();
        for (int i = 1; i < 16; i++) begin
            chk("to_wait_stall", stall, 1);
            tick();
        end
        chk("to_err_before", mem_err, 0);
        chk("to_final_stall", stall, 0);
        tick();
        clear_inputs();
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_mem", wb_mem_data, 0);
        chk("to_mem_err", mem_err, 1);
        chk("to_req", dmem_req, 0);
        tick();
        chk("to_err_sticky", mem_err, 1);
`else
        // without the timeout the access waits indefinitely
        in_valid = 1; mem_read = 1; alu_result = 64'h400;
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("no_to_stall", stall, 1);
        chk("no_to_req", dmem_req, 1);
        chk("no_to_err", mem_err, 0);
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        clear_inputs();
        chk("no_to_wb_valid", wb_valid, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
